// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the width of the per-grant byte counter.
package uart_tx_arbiter_pkg;

   localparam int COUNT_W = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      START     = 3'd2,
      WAIT_BUSY = 3'd3,
      WAIT_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: returns the first requester found when
// searching upward from ptr_i+1 (wrapping), as a one-hot vector plus index.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);

   logic          found;
   int            cand;
   logic [IW-1:0] candIdx;

   // Scan N candidates starting after the pointer; the first hit wins.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = 0;
      candIdx = '0;
      for (int k = 1; k <= N; k++) begin
         cand    = (int'(ptr_i) + k) % N;
         candIdx = IW'(cand);
         if (!found && req_i[candIdx]) begin
            found          = 1'b1;
            gnt_o[candIdx] = 1'b1;
            idx_o          = candIdx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer among N_REQ byte-stream requesters. A grant
// covers a whole frame (ended by req_last or by MAX_FRAME bytes) and rotates
// round-robin between frames. The uart_tx start/ready handshake is hidden
// behind a plain valid/ready byte interface per requester.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int MAX_FRAME = 64
) (
   input  logic                 user_clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic [N_REQ-1:0]     grant,
   output logic                 uart_start_tx,
   output logic [7:0]           uart_data,
   input  logic                 uart_ready,
   output logic                 frame_done,
   output logic                 frame_abort,
   output logic                 busy
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_FRAME);
   localparam logic [PTR_W-1:0]   PTR_INIT  = PTR_W'(N_REQ - 1);

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [7:0]         data_q, data_d;
   logic               last_q, last_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               done_q, done_d;
   logic               abort_q, abort_d;

   logic [N_REQ-1:0]   pickGnt;
   logic [PTR_W-1:0]   pickIdx;
   logic               selValid;
   logic               selLast;
   logic [7:0]         selData;

   rr_arbiter #(
      .N  (N_REQ),
      .IW (PTR_W)
   ) u_rr (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (pickGnt),
      .idx_o (pickIdx)
   );

   // Route the current owner's valid/last/data onto a single byte lane.
   always_comb begin
      selValid = 1'b0;
      selLast  = 1'b0;
      selData  = 8'h00;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q[i]) begin
            selValid = req_valid[i];
            selLast  = req_last[i];
            selData  = req_data[8*i +: 8];
         end
      end
   end

   // Next-state logic: grant, load a byte, pulse start, then follow uart_ready low and back high.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      last_d  = last_q;
      count_d = count_q;
      done_d  = 1'b0;
      abort_d = 1'b0;
      case (state_q)
         IDLE: begin
            if ((|req_valid) && uart_ready) begin
               grant_d = pickGnt;
               ptr_d   = pickIdx;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (selValid) begin
               data_d  = selData;
               last_d  = selLast;
               count_d = count_q + COUNT_W'(1);
               state_d = START;
            end
         end
         START: begin
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (!uart_ready) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (uart_ready) begin
               if (last_q) begin
                  done_d  = 1'b1;
                  grant_d = '0;
                  count_d = '0;
                  state_d = IDLE;
               end else if (count_q == MAX_COUNT) begin
                  abort_d = 1'b1;
                  grant_d = '0;
                  count_d = '0;
                  state_d = IDLE;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            count_d = '0;
         end
      endcase
   end

   // State registers with synchronous reset; a partial frame is simply dropped.
   always_ff @(posedge user_clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= PTR_INIT;
         data_q  <= 8'h00;
         last_q  <= 1'b0;
         count_q <= '0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         last_q  <= last_d;
         count_q <= count_d;
         done_q  <= done_d;
         abort_q <= abort_d;
      end
   end

   assign grant         = grant_q;
   assign uart_data     = data_q;
   assign uart_start_tx = (state_q == START);
   assign busy          = (state_q != IDLE);
   assign frame_done    = done_q;
   assign frame_abort   = abort_q;
   assign req_ready     = (state_q == LOAD) ? (grant_q & req_valid) : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx stand-in
// (ready drops two cycles after start, returns after a fixed byte time).
// Expected bytes and grant owners are queued as stimulus is issued and
// popped when the DUT pulses start or raises a grant.
module tb_uart_tx_arbiter;

   localparam int N_REQ       = 4;
   localparam int MAX_FRAME   = 64;
   localparam int BYTE_CYCLES = 10;
   localparam int TIMEOUT     = 5000;

   logic                 user_clk = 1'b0;
   logic                 rst = 1'b1;
   logic [N_REQ-1:0]     req_valid = '0;
   logic [8*N_REQ-1:0]   req_data = '0;
   logic [N_REQ-1:0]     req_last = '0;
   logic [N_REQ-1:0]     req_ready;
   logic [N_REQ-1:0]     grant;
   logic                 uart_start_tx;
   logic [7:0]           uart_data;
   logic                 uart_ready = 1'b1;
   logic                 frame_done;
   logic                 frame_abort;
   logic                 busy;

   uart_tx_arbiter #(
      .N_REQ     (N_REQ),
      .MAX_FRAME (MAX_FRAME)
   ) dut (
      .user_clk      (user_clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .grant         (grant),
      .uart_start_tx (uart_start_tx),
      .uart_data     (uart_data),
      .uart_ready    (uart_ready),
      .frame_done    (frame_done),
      .frame_abort   (frame_abort),
      .busy          (busy)
   );

   always #5 user_clk = ~user_clk;

   int errCount = 0;
   int checkCount = 0;
   int startCount = 0;
   int doneCount = 0;
   int abortCount = 0;
   int startsAtAbort = 0;
   logic checkersOn = 1'b0;
   logic [N_REQ-1:0] holdOff = '0;

   logic [7:0]       expQ[$];
   logic [N_REQ-1:0] expGrantQ[$];
   logic [8:0]       srcQ[N_REQ][$];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) else begin
         errCount++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int r, input logic [7:0] data, input logic last);
      srcQ[r].push_back({last, data});
      expQ.push_back(data);
   endtask

   task automatic expectGrant(input int r);
      expGrantQ.push_back(N_REQ'(1) << r);
   endtask

   task automatic stepCycle();
      @(posedge user_clk);
      #2;
   endtask

   // Requester models: present the head of each source queue, pop on acceptance.
   initial begin
      logic [N_REQ-1:0] acc;
      logic [8:0]       ent;
      forever begin
         @(negedge user_clk);
         acc = req_valid & req_ready;
         @(posedge user_clk);
         #1;
         for (int i = 0; i < N_REQ; i++) begin
            if (acc[i] === 1'b1 && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
            if (srcQ[i].size() > 0 && !holdOff[i]) begin
               ent = srcQ[i][0];
               req_valid[i]       = 1'b1;
               req_data[8*i +: 8] = ent[7:0];
               req_last[i]        = ent[8];
            end else begin
               req_valid[i]       = 1'b0;
               req_data[8*i +: 8] = 8'h00;
               req_last[i]        = 1'b0;
            end
         end
      end
   end

   // uart_tx stand-in: registered ready, busy for BYTE_CYCLES after a start pulse.
   initial begin
      int   txCnt;
      logic startSeen;
      txCnt = 0;
      forever begin
         @(negedge user_clk);
         startSeen = (uart_start_tx === 1'b1);
         @(posedge user_clk);
         #1;
         uart_ready = (txCnt == 0);
         if (startSeen) txCnt = BYTE_CYCLES;
         else if (txCnt > 0) txCnt--;
      end
   end

   // Per-cycle monitor: byte scoreboard, grant order, and protocol invariants.
   initial begin
      logic             held;
      logic [7:0]       heldData;
      logic [N_REQ-1:0] prevGrant;
      held = 1'b0;
      heldData = 8'h00;
      prevGrant = '0;
      forever begin
         @(negedge user_clk);
         if (checkersOn) begin
            if (uart_start_tx === 1'b1) begin
               startCount++;
               checkOutput("start_when_ready", 32'(uart_ready), 1);
               checkCount++;
               assert (expQ.size() > 0) else begin
                  errCount++;
                  $error("[TB] FAIL byte_unexpected: observed=%0h expected=none", uart_data);
               end
               if (expQ.size() > 0) checkOutput("tx_byte", 32'(uart_data), 32'(expQ.pop_front()));
               held = 1'b1;
               heldData = uart_data;
            end else if (held) begin
               checkOutput("data_stable", 32'(uart_data), 32'(heldData));
            end
            if (|(req_valid & req_ready)) held = 1'b0;
            if (rst) held = 1'b0;
            checkOutput("grant_onehot0", 32'($onehot0(grant)), 1);
            checkOutput("done_abort_excl", 32'(frame_done & frame_abort), 0);
            if (frame_done === 1'b1) doneCount++;
            if (frame_abort === 1'b1) begin
               abortCount++;
               startsAtAbort = startCount;
            end
            if (prevGrant == '0 && grant != '0) begin
               checkCount++;
               assert (expGrantQ.size() > 0) else begin
                  errCount++;
                  $error("[TB] FAIL grant_unexpected: observed=%0h expected=none", grant);
               end
               if (expGrantQ.size() > 0) checkOutput("grant_order", 32'(grant), 32'(expGrantQ.pop_front()));
            end
            prevGrant = grant;
         end
      end
   end

   // Hard stop in case a directed wait loop itself wedges.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence of scenarios.
   initial begin
      int t;
      int base;
      int base2;
      int sBase;

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge user_clk);
      #2;
      checkOutput("rst_grant", 32'(grant), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_data", 32'(uart_data), 0);
      checkOutput("rst_ready", 32'(req_ready), 0);
      checkOutput("rst_start", 32'(uart_start_tx), 0);
      checkOutput("rst_done", 32'(frame_done), 0);
      checkOutput("rst_abort", 32'(frame_abort), 0);
      rst = 1'b0;
      checkersOn = 1'b1;

      // Scenario 1: single 3-byte frame from requester 0
      $display("[TB] scenario 1: single frame");
      base = doneCount;
      expectGrant(0);
      applyStimulus(0, 8'h55, 1'b0);
      applyStimulus(0, 8'hA3, 1'b0);
      applyStimulus(0, 8'h0F, 1'b1);
      t = 0;
      while (doneCount == base && t < TIMEOUT) begin stepCycle(); t++; end
      checkOutput("s1_timeout", 32'(t < TIMEOUT), 1);
      stepCycle();
      stepCycle();
      checkOutput("s1_grant_idle", 32'(grant), 0);
      checkOutput("s1_busy", 32'(busy), 0);
      checkOutput("s1_bytes_left", 32'(expQ.size()), 0);
      checkOutput("s1_no_abort", 32'(abortCount), 0);

      // Re-centre the rotation pointer so requester 0 wins next
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      stepCycle();

      // Scenario 2: all four requesters with 2-byte frames, req0 has two
      $display("[TB] scenario 2: round robin");
      base = doneCount;
      expectGrant(0); expectGrant(1); expectGrant(2); expectGrant(3); expectGrant(0);
      applyStimulus(0, 8'h10, 1'b0); applyStimulus(0, 8'h11, 1'b1);
      applyStimulus(1, 8'h20, 1'b0); applyStimulus(1, 8'h21, 1'b1);
      applyStimulus(2, 8'h30, 1'b0); applyStimulus(2, 8'h31, 1'b1);
      applyStimulus(3, 8'h40, 1'b0); applyStimulus(3, 8'h41, 1'b1);
      applyStimulus(0, 8'h12, 1'b0); applyStimulus(0, 8'h13, 1'b1);
      t = 0;
      while (doneCount < base + 5 && t < TIMEOUT) begin stepCycle(); t++; end
      checkOutput("s2_timeout", 32'(t < TIMEOUT), 1);
      stepCycle();
      checkOutput("s2_bytes_left", 32'(expQ.size()), 0);
      checkOutput("s2_grants_left", 32'(expGrantQ.size()), 0);
      checkOutput("s2_no_abort", 32'(abortCount), 0);

      // Scenario 3: 70-byte stream from req2, cut at MAX_FRAME then re-granted
      $display("[TB] scenario 3: max frame");
      base = doneCount;
      base2 = abortCount;
      sBase = startCount;
      expectGrant(2);
      expectGrant(2);
      for (int k = 0; k < 70; k++) applyStimulus(2, 8'(k + 8'h80), 1'(k == 69));
      t = 0;
      while (doneCount == base && t < TIMEOUT) begin stepCycle(); t++; end
      checkOutput("s3_timeout", 32'(t < TIMEOUT), 1);
      checkOutput("s3_abort_count", 32'(abortCount - base2), 1);
      checkOutput("s3_abort_at_byte", 32'(startsAtAbort - sBase), MAX_FRAME);
      checkOutput("s3_total_bytes", 32'(startCount - sBase), 70);
      checkOutput("s3_grants_left", 32'(expGrantQ.size()), 0);

      // Scenario 4: req1 stalls 500 cycles mid-frame while req3 waits
      $display("[TB] scenario 4: mid-frame stall");
      base = doneCount;
      expectGrant(1);
      applyStimulus(1, 8'hB0, 1'b0);
      applyStimulus(1, 8'hB1, 1'b0);
      applyStimulus(1, 8'hB2, 1'b0);
      applyStimulus(1, 8'hB3, 1'b1);
      t = 0;
      while (grant !== 4'b0010 && t < TIMEOUT) begin stepCycle(); t++; end
      checkOutput("s4_grant_timeout", 32'(t < TIMEOUT), 1);
      expectGrant(3);
      applyStimulus(3, 8'hC0, 1'b1);
      t = 0;
      while (srcQ[1].size() > 3 && t < TIMEOUT) begin stepCycle(); t++; end
      checkOutput("s4_accept_timeout", 32'(t < TIMEOUT), 1);
      holdOff[1] = 1'b1;
      repeat (30) stepCycle();
      sBase = startCount;
      repeat (500) stepCycle();
      checkOutput("s4_no_start", 32'(startCount - sBase), 0);
      checkOutput("s4_grant_held", 32'(grant), 32'h2);
      checkOutput("s4_ready_stall", 32'(req_ready), 0);
      checkOutput("s4_busy", 32'(busy), 1);
      holdOff[1] = 1'b0;
      t = 0;
      while (doneCount < base + 2 && t < TIMEOUT) begin stepCycle(); t++; end
      checkOutput("s4_timeout", 32'(t < TIMEOUT), 1);
      stepCycle();
      checkOutput("s4_bytes_left", 32'(expQ.size()), 0);
      checkOutput("s4_grants_left", 32'(expGrantQ.size()), 0);

      // Scenario 5: reset while uart_tx is mid-byte
      $display("[TB] scenario 5: reset during byte");
      base = doneCount;
      base2 = abortCount;
      sBase = startCount;
      expectGrant(0);
      expectGrant(0);
      applyStimulus(0, 8'h11, 1'b0);
      applyStimulus(0, 8'h22, 1'b0);
      applyStimulus(0, 8'h33, 1'b1);
      t = 0;
      while (startCount == sBase && t < TIMEOUT) begin stepCycle(); t++; end
      checkOutput("s5_start_timeout", 32'(t < TIMEOUT), 1);
      t = 0;
      while (uart_ready !== 1'b0 && t < TIMEOUT) begin stepCycle(); t++; end
      checkOutput("s5_busy_timeout", 32'(t < TIMEOUT), 1);
      stepCycle();
      stepCycle();
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      checkOutput("s5_rst_grant", 32'(grant), 0);
      checkOutput("s5_rst_busy", 32'(busy), 0);
      checkOutput("s5_rst_data", 32'(uart_data), 0);
      checkOutput("s5_uart_midbyte", 32'(uart_ready), 0);
      t = 0;
      while (doneCount == base && t < TIMEOUT) begin stepCycle(); t++; end
      checkOutput("s5_timeout", 32'(t < TIMEOUT), 1);
      stepCycle();
      checkOutput("s5_bytes_left", 32'(expQ.size()), 0);
      checkOutput("s5_grants_left", 32'(expGrantQ.size()), 0);
      checkOutput("s5_no_abort", 32'(abortCount - base2), 0);
      checkOutput("s5_total_starts", 32'(startCount - sBase), 3);

      repeat (5) stepCycle();
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
